hanoi_move_gen: RTL
===================

HANOI_MOVE_GEN -- requirements
Module: hanoi_move_gen

Interface
REQ-001 Parameter S, default 4: number of disks; legal range 1..16.
REQ-002 Parameter DST, default 2: target peg for the complete tower; legal values 1 or 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full solution sequence; sampled only in IDLE or DONE.
REQ-006 ready  input  1  downstream move consumer can accept the current move.
REQ-007 valid  output  1  fr/to/disk/move_idx carry a move.
REQ-008 fr  output  2  source peg, encoded 0/1/2; never 3.
REQ-009 to  output  2  destination peg, encoded 0/1/2; never 3; never equal to fr.
REQ-010 disk  output  $clog2(S)+1  index of the moved disk (0 = smallest).
REQ-011 move_idx  output  S  1-based number of the current move.
REQ-012 done  output  1  level; the full sequence has been consumed.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 at edge t: go to RUN at t; move_idx=1, valid=1, done=0, all visible after edge t.
REQ-015 RUN: a move is consumed on any edge where valid=1 and ready=1.
REQ-016 On consumption with move_idx < 2^S-1: move_idx increments by 1 and the new move is presented on the next cycle; throughput is one move per cycle while ready=1.
REQ-017 On consumption with move_idx = 2^S-1: go to DONE; valid=0, done=1 on the next cycle.
REQ-018 While valid=1 and ready=0: fr, to, disk and move_idx hold stable.
REQ-019 start is ignored in RUN.
REQ-020 Move m source: raw_fr = (m AND (m-1)) mod 3.
REQ-021 Move m destination: raw_to = ((m OR (m-1)) + 1) mod 3.
REQ-022 Peg mapping: if (S odd) == (DST == 2), output fr/to = raw values; otherwise swap pegs 1 and 2 in both fr and to.
REQ-023 disk = number of trailing zeros of m.
REQ-024 All outputs are registered; no combinational path from start or ready to any output.
REQ-025 Mod-3 arithmetic is evaluated on S+1-bit intermediates; the m=2^S-1 term (OR result +1 = 2^S) does not overflow.

Reset
REQ-026 rst=0 forces IDLE immediately, asynchronously.
REQ-027 Reset values: valid=0, done=0, fr=0, to=0, disk=0, move_idx=0.
REQ-028 Reset asserted mid-sequence abandons the sequence; after release the block waits in IDLE for start.

Structure
REQ-029 Shared package hanoi_pkg holds peg_t (2-bit enum: PEG0, PEG1, PEG2), the FSM state typedef, and the constant PEG_INVALID=2'b11.
REQ-030 One sub-module: hanoi_mod3, combinational, S+1-bit input, 2-bit residue output; instantiated twice.
REQ-031 The fr/to outputs are directly connectable to the fr/to inputs of the tower-model block.

Verification
REQ-032 S=2, DST=2, start pulse, ready=1 -> moves (0,1),(0,2),(1,2) on 3 consecutive cycles; done=1 on the 4th cycle.
REQ-033 S=3, DST=2, ready=1 -> (0,2),(0,1),(2,1),(0,2),(1,0),(1,2),(0,2); disk sequence 0,1,0,2,0,1,0.
REQ-034 S=4, DST=2, ready low on cycles 3-5 -> move 3 (fr=1, to=2) held stable for 4 cycles; 15 moves total; last move_idx=15.
REQ-035 S=4, rst=0 asserted at move 7 -> outputs reach reset values without a clock edge; start after release restarts from move_idx=1, fr=0, to=1.
REQ-036 Scoreboard: model the three pegs as stacks; for random ready, S=1..6, both DST values -> every move is legal (never a larger disk on a smaller one), fr!=to, no encoding 3, and all S disks end on peg DST.

Source files
------------

// File: rtl/hanoi_pkg.sv
// Shared types for the Towers of Hanoi move generator: peg encoding and FSM states.
package hanoi_pkg;

    typedef enum logic [1:0] {
        PEG0 = 2'd0,
        PEG1 = 2'd1,
        PEG2 = 2'd2
    } peg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] PEG_INVALID = 2'b11;

    // Exchanges pegs 1 and 2 so the tower lands on the requested target peg.
    function automatic peg_t peg_swap12(input peg_t p, input bit swap);
        peg_t r;
        r = p;
        if (swap) begin
            case (p)
                PEG1:    r = PEG2;
                PEG2:    r = PEG1;
                default: r = p;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// Combinational residue modulo 3 of an unsigned W-bit value.
module hanoi_mod3 #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_val,
    output logic [1:0]   o_res
);

    assign o_res = 2'(i_val % W'(3));

endmodule

// File: rtl/hanoi_move_gen.sv
// Streams the 2^S-1 moves of an S-disk Towers of Hanoi solution, one per accepted
// handshake, using the closed-form source/destination formula for move m.
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int unsigned S   = 4,
    parameter int unsigned DST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ready,
    output logic                 valid,
    output logic [1:0]           fr,
    output logic [1:0]           to,
    output logic [$clog2(S):0]   disk,
    output logic [S-1:0]         move_idx,
    output logic                 done
);

    localparam int unsigned DW = $clog2(S) + 1;
    localparam int unsigned MW = S + 1;
    localparam bit          SWAP = ((S % 2) == 1) != (DST == 2);
    localparam logic [S-1:0] IDX_MAX = '1;

    state_t          r_state, w_state_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_done, w_done_nxt;
    peg_t            r_fr, w_fr_nxt;
    peg_t            r_to, w_to_nxt;
    logic [DW-1:0]   r_disk, w_disk_nxt;
    logic [S-1:0]    r_move_idx, w_idx_nxt;
    logic            w_load;

    logic [S-1:0]    w_m;
    logic [S-1:0]    w_m_dec;
    logic [MW-1:0]   w_and;
    logic [MW-1:0]   w_or_inc;
    logic [1:0]      w_fr_raw;
    logic [1:0]      w_to_raw;
    peg_t            w_fr;
    peg_t            w_to;
    logic [DW-1:0]   w_tz;

    // Next move number: 1 when launching a sequence, otherwise the successor.
    assign w_m      = (r_state == ST_RUN) ? r_move_idx + S'(1) : S'(1);
    assign w_m_dec  = w_m - S'(1);
    assign w_and    = MW'(w_m & w_m_dec);
    assign w_or_inc = MW'(w_m | w_m_dec) + MW'(1);

    hanoi_mod3 #(.W(MW)) u_mod3_fr (
        .i_val (w_and),
        .o_res (w_fr_raw)
    );

    hanoi_mod3 #(.W(MW)) u_mod3_to (
        .i_val (w_or_inc),
        .o_res (w_to_raw)
    );

    assign w_fr = peg_swap12(peg_t'(w_fr_raw), SWAP);
    assign w_to = peg_swap12(peg_t'(w_to_raw), SWAP);

    // Moved disk is the count of trailing zeros of the move number.
    always_comb begin
        w_tz = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (w_m[i]) w_tz = DW'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        w_fr_nxt    = r_fr;
        w_to_nxt    = r_to;
        w_disk_nxt  = r_disk;
        w_idx_nxt   = r_move_idx;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_valid && ready) begin
                    if (r_move_idx == IDX_MAX) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_fr_nxt   = w_fr;
            w_to_nxt   = w_to;
            w_disk_nxt = w_tz;
            w_idx_nxt  = w_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_fr       <= PEG0;
            r_to       <= PEG0;
            r_disk     <= '0;
            r_move_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_fr       <= w_fr_nxt;
            r_to       <= w_to_nxt;
            r_disk     <= w_disk_nxt;
            r_move_idx <= w_idx_nxt;
        end
    end

    assign valid    = r_valid;
    assign done     = r_done;
    assign fr       = r_fr;
    assign to       = r_to;
    assign disk     = r_disk;
    assign move_idx = r_move_idx;

endmodule
